// File: rtl/gate_window_scheduler_pkg.sv
// rtl/gate_window_scheduler_pkg.sv - shared types and constants for the gate window scheduler
package gate_window_scheduler_pkg;

    localparam int CNT_W_DEF  = 64;
    localparam int PER_W_DEF  = 32;
    localparam int MIN_PERIOD = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/gate_window_scheduler_sample_holding_reg.sv
// rtl/gate_window_scheduler_sample_holding_reg.sv - valid/ready output register with overwrite and overrun flag
//   clk, rst         : clock, synchronous active-high reset
//   capture_i        : load capture_data_i this cycle
//   capture_data_i   : value to hold
//   ready_i          : downstream accepts when valid_o && ready_i
//   clear_overrun_i  : clears the sticky overrun flag
//   sample_o         : held value
//   valid_o          : held value not yet consumed
//   overrun_o        : sticky, a capture replaced an unconsumed value
module sample_holding_reg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         capture_i,
    input  logic [W-1:0] capture_data_i,
    input  logic         ready_i,
    input  logic         clear_overrun_i,
    output logic [W-1:0] sample_o,
    output logic         valid_o,
    output logic         overrun_o
);

    logic [W-1:0] sample_q;
    logic         valid_q;
    logic         overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // A landing capture wins over a same-cycle consume: valid stays high.
            if (capture_i) begin
                sample_q <= capture_data_i;
                valid_q  <= 1'b1;
            end else if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end

            if (capture_i && valid_q && !ready_i) begin
                overrun_q <= 1'b1;
            end else if (clear_overrun_i) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign sample_o  = sample_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/gate_window_scheduler.sv
// rtl/gate_window_scheduler.sv - sequences a shared event counter into fixed-length measurement windows
//   clk, rst                  : clock, synchronous active-high reset
//   start, stop, continuous   : control; mode and period latched at start
//   period                    : window length in cycles (values below 2 act as 2)
//   event_in                  : raw event, one count per high cycle
//   cnt_out                   : counter result, valid one cycle after cnt_trigger
//   cnt_increment, cnt_trigger: strobes to the counter
//   sample, sample_valid, sample_ready : captured window count and handshake
//   busy, overrun, event_lost : status
module gate_window_scheduler
    import gate_window_scheduler_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PER_W = PER_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             continuous,
    input  logic [PER_W-1:0] period,
    input  logic             event_in,
    input  logic [CNT_W-1:0] cnt_out,
    output logic             cnt_increment,
    output logic             cnt_trigger,
    output logic [CNT_W-1:0] sample,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             busy,
    output logic             overrun,
    output logic             event_lost
);

    state_e           state_q, state_d;
    logic [PER_W-1:0] timer_q, timer_d;
    logic [PER_W-1:0] per_q, per_d;
    logic             cont_q, cont_d;
    logic             stop_pend_q, stop_pend_d;
    logic             arm_q;
    logic             lost_q;

    logic             run_trig;
    logic             start_acc;
    logic [PER_W-1:0] per_eff;

    assign per_eff = (period < PER_W'(MIN_PERIOD)) ? PER_W'(MIN_PERIOD) : period;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        per_d         = per_q;
        cont_d        = cont_q;
        stop_pend_d   = stop_pend_q;
        cnt_increment = 1'b0;
        cnt_trigger   = 1'b0;
        run_trig      = 1'b0;
        start_acc     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    per_d       = per_eff;
                    cont_d      = continuous;
                    stop_pend_d = 1'b0;
                    start_acc   = 1'b1;
                    state_d     = ST_PRIME;
                end
            end
            ST_PRIME: begin
                // Clears the counter; its output this time is stale and never captured.
                cnt_trigger = 1'b1;
                timer_d     = per_q - PER_W'(1);
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (timer_q != '0) begin
                    cnt_increment = event_in;
                    timer_d       = timer_q - PER_W'(1);
                end else begin
                    cnt_trigger = 1'b1;
                    run_trig    = 1'b1;
                    if (cont_q && !stop_pend_q) begin
                        timer_d = per_q - PER_W'(1);
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            per_q       <= '0;
            cont_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            arm_q       <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            per_q       <= per_d;
            cont_q      <= cont_d;
            stop_pend_q <= stop_pend_d;
            // Counter output is valid the cycle after a RUN trigger; arm the capture for then.
            arm_q       <= run_trig;
            lost_q      <= run_trig & event_in;
        end
    end

    sample_holding_reg #(
        .W(CNT_W)
    ) u_hold (
        .clk            (clk),
        .rst            (rst),
        .capture_i      (arm_q),
        .capture_data_i (cnt_out),
        .ready_i        (sample_ready),
        .clear_overrun_i(start_acc),
        .sample_o       (sample),
        .valid_o        (sample_valid),
        .overrun_o      (overrun)
    );

    assign busy       = (state_q != ST_IDLE);
    assign event_lost = lost_q;

endmodule

// File: tb/tb_gate_window_scheduler.sv
// tb/tb_gate_window_scheduler.sv - scoreboard testbench for gate_window_scheduler
module tb_gate_window_scheduler;

    localparam int CNT_W = 64;
    localparam int PER_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             continuous = 1'b0;
    logic [PER_W-1:0] period = '0;
    logic             event_in = 1'b0;
    logic [CNT_W-1:0] cnt_out = '0;
    logic             sample_ready = 1'b0;
    logic             cnt_increment, cnt_trigger, sample_valid, busy, overrun, event_lost;
    logic [CNT_W-1:0] sample;

    gate_window_scheduler #(.CNT_W(CNT_W), .PER_W(PER_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .continuous   (continuous),
        .period       (period),
        .event_in     (event_in),
        .cnt_out      (cnt_out),
        .cnt_increment(cnt_increment),
        .cnt_trigger  (cnt_trigger),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .overrun      (overrun),
        .event_lost   (event_lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External counter: trigger publishes the count next cycle and clears it.
    logic [CNT_W-1:0] ctr = 64'h0123_4567_89ab_cdef;
    always @(posedge clk) begin
        if (cnt_trigger) begin
            cnt_out <= ctr;
            ctr     <= '0;
        end else if (cnt_increment) begin
            ctr <= ctr + 64'd1;
        end
    end

    int n_chk  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: windows are described by their trigger cycle numbers.
    typedef struct {
        int         land;
        logic [63:0] val;
    } cap_t;
    cap_t exp_q[$];

    bit          m_active = 0, m_draining = 0, m_cont = 0, m_stopq = 0;
    int          m_prime = 0, m_next = 0, m_p = 2, m_acc = 0;
    bit          slot_full = 0, exp_ov = 0, exp_lost = 0;
    logic [63:0] slot_val = '0;

    always @(negedge clk) begin
        int c;
        bit e_trig, e_inc, stop_old, next_lost;
        c      = cyc;
        e_trig = m_active && !m_draining && (c == m_prime || c == m_next);
        e_inc  = m_active && !m_draining && c > m_prime && c < m_next && event_in;
        if (mon_en) begin
            chk("busy", busy, m_active);
            chk("cnt_trigger", cnt_trigger, e_trig);
            chk("cnt_increment", cnt_increment, e_inc);
            chk("sample_valid", sample_valid, slot_full);
            chk("overrun", overrun, exp_ov);
            chk("event_lost", event_lost, exp_lost);
            if (sample_valid && sample_ready && slot_full)
                chk("sample", sample, slot_val);
        end
        if (rst) begin
            m_active = 0; m_draining = 0; exp_q.delete();
            slot_full = 0; slot_val = '0; exp_ov = 0; exp_lost = 0;
        end else begin
            next_lost = 0;
            if (slot_full && sample_ready) slot_full = 0;
            if (exp_q.size() > 0 && exp_q[0].land == c + 1) begin
                if (slot_full) exp_ov = 1;
                slot_val  = exp_q[0].val;
                slot_full = 1;
                void'(exp_q.pop_front());
            end
            if (!m_active) begin
                if (start) begin
                    m_active = 1; m_draining = 0; m_prime = c + 1;
                    m_p = (period < 2) ? 2 : int'(period);
                    m_next = c + 1 + m_p; m_cont = continuous; m_stopq = 0;
                    m_acc = 0; exp_ov = 0;
                end
            end else if (m_draining) begin
                m_active = 0;
            end else if (c > m_prime) begin
                stop_old = m_stopq;
                if (stop) m_stopq = 1;
                if (c == m_next) begin
                    exp_q.push_back('{c + 2, 64'(m_acc)});
                    next_lost = event_in;
                    m_acc = 0;
                    if (m_cont && !stop_old) m_next = m_next + m_p;
                    else m_draining = 1;
                end else if (event_in) begin
                    m_acc++;
                end
            end
            exp_lost = next_lost;
        end
    end

    task automatic tick(input int ev_pct, input int rdy_pct);
        event_in     = ($urandom_range(0, 99) < ev_pct);
        sample_ready = ($urandom_range(0, 99) < rdy_pct);
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int p, input bit cont, input int ev_pct, input int rdy_pct);
        start = 1; period = PER_W'(p); continuous = cont;
        tick(ev_pct, rdy_pct);
        start = 0;
    endtask

    task automatic do_stop(input int ev_pct, input int rdy_pct);
        stop = 1;
        tick(ev_pct, rdy_pct);
        stop = 0;
    endtask

    task automatic wait_idle(input int ev_pct, input int rdy_pct);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick(ev_pct, rdy_pct);
            n++;
        end
        if (busy) begin
            n_chk++; n_fail++;
            $display("FAIL wait_idle timeout at cycle %0d: busy=%0b required=0", cyc, busy);
        end
        repeat (4) tick(0, rdy_pct);
    endtask

    task automatic drain();
        repeat (3) tick(0, 100);
    endtask

    initial begin
        // Reset, with start held high that must be ignored.
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1;
        start = 1; period = 4; continuous = 1;
        repeat (3) tick(100, 100);
        start = 0; rst = 0;
        chk("reset sample", sample, 64'd0);
        chk("reset valid", sample_valid, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset strobes", {cnt_increment, cnt_trigger}, 2'b00);
        chk("reset flags", {overrun, event_lost}, 2'b00);

        // Continuous, period 4, events every cycle, ready always.
        do_start(4, 1, 100, 100);
        repeat (18) tick(100, 100);
        do_stop(100, 100);
        wait_idle(100, 100);

        // One-shot, period 10, slow consumer.
        do_start(10, 0, 50, 0);
        wait_idle(50, 0);
        repeat (5) tick(0, 0);
        chk("one-shot held valid", sample_valid, 1'b1);
        drain();

        // Overrun, period 3, never ready.
        do_start(3, 1, 100, 0);
        repeat (12) tick(100, 0);
        do_stop(100, 0);
        wait_idle(100, 0);
        chk("overrun set", overrun, 1'b1);
        do_start(2, 0, 100, 100);
        chk("overrun cleared by start", overrun, 1'b0);
        wait_idle(100, 100);

        // Graceful stop mid-window, then period clamp.
        do_start(8, 1, 70, 100);
        repeat (3) tick(70, 100);
        do_stop(70, 100);
        wait_idle(70, 100);
        do_start(0, 0, 100, 100);
        wait_idle(100, 100);
        do_start(1, 0, 100, 100);
        wait_idle(100, 100);

        // Lost events with random handshake, then reset mid-run.
        do_start(5, 1, 60, 50);
        repeat (30) tick(60, 50);
        rst = 1;
        tick(60, 50);
        rst = 0;
        chk("abort busy", busy, 1'b0);
        chk("abort valid", sample_valid, 1'b0);
        chk("abort strobes", {cnt_increment, cnt_trigger}, 2'b00);
        drain();

        // Random configurations.
        for (int k = 0; k < 8; k++) begin
            int p, ev, rd, len;
            bit cont;
            p = $urandom_range(0, 7); cont = 1'($urandom_range(0, 1));
            ev = $urandom_range(0, 100); rd = $urandom_range(0, 100);
            len = $urandom_range(3, 25);
            do_start(p, cont, ev, rd);
            repeat (len) tick(ev, rd);
            do_stop(ev, rd);
            wait_idle(ev, rd);
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_window_scheduler.md
Name: gate_window_scheduler

Overview:
- Controller that sequences the shared 64-bit event counter (increment/trigger/out interface) into fixed-length measurement windows.
- Drives the counter's increment and trigger strobes, captures each window's result from the counter output, and presents it downstream on a valid/ready interface.
- Supports one-shot and continuous modes, graceful stop, overrun and lost-event reporting.
- Sits between the raw event source and the counter, one instance per measured channel.

Parameters:
- CNT_W, 64, width of counter value and sample.
- PER_W, 32, width of window period.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin measurement; honoured only in IDLE.
- stop  in  1  request graceful stop; honoured only in RUN.
- continuous  in  1  mode select, latched at start (1 = back-to-back windows, 0 = single window).
- period  in  PER_W  window length in clk cycles, latched at start.
- event_in  in  1  raw event, one count per high cycle.
- cnt_out  in  CNT_W  counter result (counter updates this one cycle after trigger).
- cnt_increment  out  1  to counter increment.
- cnt_trigger  out  1  to counter trigger.
- sample  out  CNT_W  captured window count.
- sample_valid  out  1  sample holds an unconsumed value.
- sample_ready  in  1  downstream accepts the sample when valid && ready.
- busy  out  1  state != IDLE.
- overrun  out  1  sticky; a new capture overwrote an unconsumed sample.
- event_lost  out  1  one-cycle pulse; an event fell on a RUN trigger cycle.

Behaviour:
- Reset: state IDLE; all outputs 0 (sample, valid, overrun, event_lost, strobes); latched period/mode and stop_pending cleared. Reset mid-window aborts with no capture.
- Effective period P = max(period, 2), latched at start.
- States:
  - IDLE: strobes 0. On start, latch P/mode, clear overrun and stop_pending, go to PRIME. Start and stop in the same cycle: start wins, stop ignored.
  - PRIME (1 cycle): cnt_trigger=1 clears the counter; no capture is armed; go to RUN with timer = P-1.
  - RUN: while timer != 0, cnt_increment = event_in, cnt_trigger = 0, timer decrements.
  - RUN end of window (timer == 0): cnt_trigger = 1, cnt_increment = 0, capture is armed.
    - If continuous && !stop_pending: reload timer = P-1 and stay in RUN (windows back-to-back, P cycles each, P-1 counting cycles).
    - Otherwise go to DRAIN.
  - DRAIN (1 cycle): strobes 0; capture completes; go to IDLE.
- stop in RUN sets stop_pending; the current window finishes normally and its sample is delivered. A stop outside RUN is ignored.
- Capture pipeline:
  - In the cycle after a RUN trigger, cnt_out is valid and is registered into sample.
  - sample_valid rises 2 cycles after the trigger cycle.
- Handshake:
  - sample_valid clears on valid && ready unless a capture lands in that same cycle; a new capture wins and valid stays 1.
  - A capture while valid && !ready overwrites sample and sets overrun, which stays set until the next accepted start.
  - sample and sample_valid persist through IDLE until consumed.
- event_lost: registered, asserted the cycle after a RUN trigger cycle with event_in = 1. PRIME-cycle events are not flagged.
- Counter wrap at 2^CNT_W is the counter's concern; it is passed through unchanged.
- cnt_increment and cnt_trigger are never 1 in the same cycle.

Decomposition:
- Shared package holds:
  - state enum (IDLE, PRIME, RUN, DRAIN);
  - MIN_PERIOD = 2;
  - default CNT_W and PER_W.
- One natural sub-module: sample_holding_reg, the valid/ready output register with overwrite/overrun logic.
- FSM and timer stay in the top module.

Test Plan:
- Reset values: after rst, all outputs 0; start while rst=1 has no effect.
- Continuous sampling: period=4, continuous=1, event_in=1 constantly, sample_ready=1 -> trigger every 4 cycles; each sample = 3; first sample_valid 2 cycles after the first RUN trigger.
- One-shot with slow consumer: period=10, continuous=0, 5 events in counting cycles -> one sample = 5; busy drops after DRAIN; sample_valid held until sample_ready pulses.
- Overrun: period=3, continuous=1, sample_ready=0 -> second capture sets overrun; sample shows the latest count; the next start clears overrun.
- Graceful stop and period clamp: stop asserted mid-window (period=8) -> that window's sample is delivered, then IDLE. Period=0 or 1 behaves as 2 (sample = 1 with event_in=1).
- Lost events and reset abort: event_in high on a trigger cycle -> event_lost pulses one cycle later and is excluded from the count. rst mid-RUN -> immediate IDLE, no sample, strobes 0.
